// File: rtl/grey_pkg.sv
// Shared definitions for the Gray-code pointer path: default width, direction
// encoding and the scalar binary<->Gray conversion functions.
package grey_pkg;

    localparam int GREY_W_DEFAULT = 16;
    localparam int GREY_W_MAX     = 64;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_e;

    function automatic logic [GREY_W_MAX-1:0] bin2grey(input logic [GREY_W_MAX-1:0] x);
        return x ^ (x >> 1);
    endfunction

    // Each binary bit is the XOR of all Gray bits at or above it.
    function automatic logic [GREY_W_MAX-1:0] grey2bin(input logic [GREY_W_MAX-1:0] x);
        logic [GREY_W_MAX-1:0] r;
        r[GREY_W_MAX-1] = x[GREY_W_MAX-1];
        for (int i = GREY_W_MAX-2; i >= 0; i--) begin
            r[i] = r[i+1] ^ x[i];
        end
        return r;
    endfunction

endpackage

// File: rtl/bin2grey_enc.sv
// Purely combinational WIDTH-bit binary-to-Gray encoder, reusable on any
// pointer path that needs Gray encoding.
module bin2grey_enc
    import grey_pkg::*;
#(
    parameter int WIDTH = GREY_W_DEFAULT
) (
    input  logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] grey
);

    assign grey = bin ^ (bin >> 1);

endmodule

// File: rtl/binary_grey_counter.sv
// Up/down binary counter with synchronous load and registered Gray output.
// Define GREY_STEP_CHECK_EN to add the sticky single-bit-step checker on err.
module binary_grey_counter
    import grey_pkg::*;
#(
    parameter int WIDTH = GREY_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_bin,
    output logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] g,
    output logic             wrap,
    output logic             changed,
    output logic             err
);

    dir_e             dir;
    logic [WIDTH:0]   inc_full;
    logic [WIDTH:0]   dec_full;
    logic [WIDTH-1:0] next_bin;
    logic [WIDTH-1:0] next_grey;
    logic             wrap_next;

    assign dir = dir_e'(up);

    // The extra top bit is the carry (increment) or borrow (decrement) out.
    assign inc_full = {1'b0, b} + (WIDTH+1)'(1);
    assign dec_full = {1'b0, b} - (WIDTH+1)'(1);

    // NOTE: every output of this block gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    always_comb begin
        next_bin  = b;
        wrap_next = 1'b0;
        if (load) begin
            next_bin = load_bin;
        end else if (en) begin
            if (dir == DIR_UP) begin
                next_bin  = inc_full[WIDTH-1:0];
                wrap_next = inc_full[WIDTH];
            end else begin
                next_bin  = dec_full[WIDTH-1:0];
                wrap_next = dec_full[WIDTH];
            end
        end
    end

    // Encoding the next value keeps b and g updating on the same edge.
    bin2grey_enc #(
        .WIDTH (WIDTH)
    ) u_enc (
        .bin  (next_bin),
        .grey (next_grey)
    );

    // NOTE: state uses non-blocking assignments so every register samples the
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            b       <= '0;
            g       <= '0;
            wrap    <= 1'b0;
            changed <= 1'b0;
        end else begin
            b       <= next_bin;
            g       <= next_grey;
            wrap    <= wrap_next;
            changed <= (next_bin != b);
        end
    end

`ifdef GREY_STEP_CHECK_EN
    logic [WIDTH-1:0] g_prev;
    logic             step;
    logic             step_q;

    assign step = en && !load;

    // The check runs one edge after a counting step, comparing the new g
    // against the value it replaced.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            g_prev <= '0;
            step_q <= 1'b0;
            err    <= 1'b0;
        end else begin
            g_prev <= g;
            step_q <= step;
            if (step_q && ($countones(g_prev ^ g) != 1)) begin
                err <= 1'b1;
            end
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_binary_grey_counter.sv
// Self-checking bench for binary_grey_counter: directed scenarios plus a
// randomized run against an integer reference model of the counter.
module tb_binary_grey_counter;
    import grey_pkg::*;

    localparam int W   = 16;
    localparam int MOD = 1 << W;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic         up;
    logic         load;
    logic [W-1:0] load_bin;
    logic [W-1:0] b;
    logic [W-1:0] g;
    logic         wrap;
    logic         changed;
    logic         err;

    int checks = 0;
    int errors = 0;

    int           model_b;
    logic [W-1:0] exp_b;
    logic [W-1:0] exp_g;
    logic         exp_wrap;
    logic         exp_changed;

    always #5 clk = ~clk;

    binary_grey_counter #(
        .WIDTH (W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .up       (up),
        .load     (load),
        .load_bin (load_bin),
        .b        (b),
        .g        (g),
        .wrap     (wrap),
        .changed  (changed),
        .err      (err)
    );

    function automatic logic [W-1:0] gray_of(input int unsigned v);
        logic [63:0] x;
        x = 64'(v);
        return W'(bin2grey(x));
    endfunction

    // Called at a falling edge: drives inputs, advances the model, and returns
    // at the next falling edge with the DUT outputs settled.
    task automatic cycle(input logic e, input logic u, input logic l, input logic [W-1:0] lb);
        int raw;
        int prev;
        en       = e;
        up       = u;
        load     = l;
        load_bin = lb;
        prev     = model_b;
        exp_wrap = 1'b0;
        if (l) begin
            model_b = int'(lb);
        end else if (e) begin
            raw      = u ? model_b + 1 : model_b - 1;
            exp_wrap = (raw < 0) || (raw >= MOD);
            model_b  = (raw + MOD) % MOD;
        end
        exp_b       = W'(model_b);
        exp_g       = gray_of(model_b);
        exp_changed = (model_b != prev);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        en = 1'b0; up = 1'b0; load = 1'b0; load_bin = '0;
        @(negedge clk);
        checks++;
        if ({b, g, wrap, changed, err} !== '0) begin
            errors++;
            $display("FAIL reset_state got b=%h g=%h wrap=%b changed=%b err=%b want all 0",
                     b, g, wrap, changed, err);
        end
        rst = 1'b0;
        model_b = 0;
    endtask

    task automatic test_count_up();
        logic [W-1:0] g_tab [4];
        g_tab = '{16'h0001, 16'h0003, 16'h0002, 16'h0006};
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 1'b1, 1'b0, '0);
            checks++;
            if ({b, g, wrap, changed, err} !== {W'(i + 1), g_tab[i], 1'b0, 1'b1, 1'b0}) begin
                errors++;
                $display("FAIL count_up[%0d] got b=%h g=%h wrap=%b changed=%b err=%b want b=%h g=%h wrap=0 changed=1 err=0",
                         i, b, g, wrap, changed, err, W'(i + 1), g_tab[i]);
            end
        end
    endtask

    task automatic test_wrap_up();
        cycle(1'b0, 1'b0, 1'b1, 16'hFFFF);
        checks++;
        if ({b, g, wrap} !== {16'hFFFF, 16'h8000, 1'b0}) begin
            errors++;
            $display("FAIL wrap_up_load got b=%h g=%h wrap=%b want b=ffff g=8000 wrap=0", b, g, wrap);
        end
        cycle(1'b1, 1'b1, 1'b0, '0);
        checks++;
        if ({b, g, wrap, changed} !== {16'h0000, 16'h0000, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL wrap_up_step got b=%h g=%h wrap=%b changed=%b want b=0000 g=0000 wrap=1 changed=1",
                     b, g, wrap, changed);
        end
        cycle(1'b0, 1'b0, 1'b0, '0);
        checks++;
        if ({b, wrap, changed} !== {16'h0000, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL wrap_up_hold got b=%h wrap=%b changed=%b want b=0000 wrap=0 changed=0", b, wrap, changed);
        end
    endtask

    task automatic test_wrap_down();
        cycle(1'b1, 1'b0, 1'b0, '0);
        checks++;
        if ({b, g, wrap} !== {16'hFFFF, 16'h8000, 1'b1}) begin
            errors++;
            $display("FAIL wrap_down_step got b=%h g=%h wrap=%b want b=ffff g=8000 wrap=1", b, g, wrap);
        end
        cycle(1'b1, 1'b0, 1'b0, '0);
        checks++;
        if ({b, g, wrap} !== {16'hFFFE, 16'h8001, 1'b0}) begin
            errors++;
            $display("FAIL wrap_down_next got b=%h g=%h wrap=%b want b=fffe g=8001 wrap=0", b, g, wrap);
        end
    endtask

    task automatic test_load_priority();
        cycle(1'b1, 1'b1, 1'b1, 16'h00FF);
        checks++;
        if ({b, g, wrap, changed} !== {16'h00FF, 16'h0080, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL load_wins got b=%h g=%h wrap=%b changed=%b want b=00ff g=0080 wrap=0 changed=1",
                     b, g, wrap, changed);
        end
        cycle(1'b0, 1'b0, 1'b1, 16'h00FF);
        checks++;
        if ({b, changed} !== {16'h00FF, 1'b0}) begin
            errors++;
            $display("FAIL reload_same got b=%h changed=%b want b=00ff changed=0", b, changed);
        end
        cycle(1'b0, 1'b0, 1'b1, 16'hFFFF);
        cycle(1'b1, 1'b1, 1'b1, 16'h0000);
        checks++;
        if ({b, g, wrap, changed} !== {16'h0000, 16'h0000, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL load_no_wrap got b=%h g=%h wrap=%b changed=%b want b=0000 g=0000 wrap=0 changed=1",
                     b, g, wrap, changed);
        end
    endtask

    task automatic test_async_reset();
        cycle(1'b0, 1'b0, 1'b1, 16'h1232);
        cycle(1'b1, 1'b1, 1'b0, '0);
        cycle(1'b1, 1'b1, 1'b0, '0);
        checks++;
        if (b !== 16'h1234) begin
            errors++;
            $display("FAIL pre_reset_count got b=%h want 1234", b);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({b, g, wrap, changed, err} !== '0) begin
            errors++;
            $display("FAIL async_reset got b=%h g=%h wrap=%b changed=%b err=%b want all 0",
                     b, g, wrap, changed, err);
        end
        @(negedge clk);
        checks++;
        if ({b, g, wrap, changed, err} !== '0) begin
            errors++;
            $display("FAIL reset_held got b=%h g=%h want all 0", b, g);
        end
        rst = 1'b0;
        model_b = 0;
        cycle(1'b1, 1'b1, 1'b0, '0);
        checks++;
        if ({b, g, changed} !== {16'h0001, 16'h0001, 1'b1}) begin
            errors++;
            $display("FAIL resume_after_reset got b=%h g=%h changed=%b want b=0001 g=0001 changed=1", b, g, changed);
        end
    endtask

    task automatic test_random(input int n);
        logic [W-1:0] g_before;
        logic         e;
        logic         u;
        logic         l;
        for (int i = 0; i < n; i++) begin
            e = 1'($urandom_range(0, 3) != 0);
            u = 1'($urandom);
            l = 1'($urandom_range(0, 15) == 0);
            g_before = g;
            // Loads near the wrap points exercise carry and borrow often.
            cycle(e, u, l, W'($urandom_range(0, 3) == 0 ? $urandom_range(0, 1) * (MOD - 1) : $urandom));
            checks++;
            if ({b, g, wrap, changed, err} !== {exp_b, exp_g, exp_wrap, exp_changed, 1'b0}) begin
                errors++;
                $display("FAIL random[%0d] got b=%h g=%h wrap=%b changed=%b err=%b want b=%h g=%h wrap=%b changed=%b err=0",
                         i, b, g, wrap, changed, err, exp_b, exp_g, exp_wrap, exp_changed);
            end
            checks++;
            if (W'(grey2bin(64'(g))) !== b) begin
                errors++;
                $display("FAIL random_decode[%0d] got grey2bin(g)=%h want b=%h", i, W'(grey2bin(64'(g))), b);
            end
            if (!l && e) begin
                checks++;
                if ($countones(g_before ^ g) != 1) begin
                    errors++;
                    $display("FAIL random_one_bit[%0d] got %0d changed g bits want 1", i, $countones(g_before ^ g));
                end
            end
        end
    endtask

`ifdef GREY_STEP_CHECK_EN
    task automatic test_step_check();
        logic [W-1:0] g_before;
        logic [W-1:0] bad_g;
        int           bad_steps;
        cycle(1'b0, 1'b0, 1'b1, 16'h0000);
        bad_steps = 0;
        for (int i = 0; i < 70000; i++) begin
            g_before = g;
            cycle(1'b1, 1'b1, 1'b0, '0);
            if ($countones(g_before ^ g) != 1 || g !== exp_g) bad_steps++;
        end
        checks++;
        if (bad_steps != 0 || err !== 1'b0) begin
            errors++;
            $display("FAIL long_up_count got bad_steps=%0d err=%b want bad_steps=0 err=0", bad_steps, err);
        end
        // Corrupt g right after a counting step so it differs in two bits
        // from the value it replaced.
        cycle(1'b1, 1'b1, 1'b0, '0);
        bad_g = gray_of((model_b + MOD - 1) % MOD) ^ 16'h0003;
        en = 1'b0;
        force dut.g = bad_g;
        @(posedge clk);
        @(negedge clk);
        release dut.g;
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL step_err_set got err=%b want 1", err);
        end
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, 1'b0, '0);
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL step_err_sticky got err=%b want 1", err);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL step_err_clear got err=%b want 0", err);
        end
        @(negedge clk);
        rst = 1'b0;
        model_b = 0;
    endtask
`endif

    initial begin
        test_reset();
        test_count_up();
        test_wrap_up();
        test_wrap_down();
        test_load_priority();
        test_async_reset();
        test_random(3000);
`ifdef GREY_STEP_CHECK_EN
        test_step_check();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
